// File: rtl/enemy_hit_detect.sv
`default_nettype none
// ============================================================================
//  Module     : enemy_hit_detect
//  Description: Frame-rate hit detection and life cycle for one enemy plane.
//               On each frame tick (vs_neg) the player bullet is tested
//               against the enemy hit box. A hit starts an explosion
//               animation, then a dead period, then the enemy respawns.
//               Every hit bumps a 4-digit BCD score.
//  Revision   : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock (single domain)
//    rst            in   asynchronous active-high reset
//    vs_neg         in   one-cycle frame tick (vsync falling edge)
//    enemy_x/_y     in   enemy centre position [10:0]
//    bullet_x/_y    in   player bullet centre position [10:0]
//    bullet_valid   in   bullet is in flight
//    hit            out  one-cycle pulse when a hit is registered
//    bullet_clear   out  one-cycle pulse asking the bullet owner to retire it
//    enemy_alive    out  enemy drawable and hittable (registered)
//    explode_frame  out  explosion sprite index [2:0], 0 when not exploding
//    respawn        out  one-cycle pulse on return to ALIVE
//    score          out  four BCD digits, [15:12] = thousands
// ============================================================================
module enemy_hit_detect #(
  parameter logic [10:0] ENEMY_PLANE_HALF_WIDTH  = 11'd64,
  parameter logic [10:0] ENEMY_PLANE_HALF_HEIGHT = 11'd64,
  parameter logic [5:0]  EXPLODE_FRAMES          = 6'd32,
  parameter logic [6:0]  RESPAWN_FRAMES          = 7'd60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs_neg,
  input  logic [10:0] enemy_x,
  input  logic [10:0] enemy_y,
  input  logic [10:0] bullet_x,
  input  logic [10:0] bullet_y,
  input  logic        bullet_valid,
  output logic        hit,
  output logic        bullet_clear,
  output logic        enemy_alive,
  output logic [2:0]  explode_frame,
  output logic        respawn,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_EXPLODE = 2'd1,
    ST_DEAD    = 2'd2
  } state_t;

  state_t      r_state,     w_state_nxt;
  logic [5:0]  r_exp_cnt,   w_exp_cnt_nxt;
  logic [6:0]  r_dead_cnt,  w_dead_cnt_nxt;
  logic [15:0] r_score,     w_score_nxt;
  logic        r_hit,       w_hit_nxt;
  logic        r_respawn,   w_respawn_nxt;
  logic        r_alive,     w_alive_nxt;
  logic [2:0]  r_frame,     w_frame_nxt;

  // --------------------------------------------------------------------------
  // Overlap test. Differences are taken one bit wider than the coordinates so
  // a bullet at x=2047 against an enemy at x=0 is far away, not adjacent.
  // --------------------------------------------------------------------------
  logic [11:0] w_dx, w_dy, w_adx, w_ady;
  logic        w_overlap;

  assign w_dx  = {1'b0, bullet_x} - {1'b0, enemy_x};
  assign w_dy  = {1'b0, bullet_y} - {1'b0, enemy_y};
  assign w_adx = w_dx[11] ? (~w_dx + 12'd1) : w_dx;
  assign w_ady = w_dy[11] ? (~w_dy + 12'd1) : w_dy;
  // Strict compare: a bullet exactly on the box boundary is a miss.
  assign w_overlap = (w_adx < {1'b0, ENEMY_PLANE_HALF_WIDTH}) &&
                     (w_ady < {1'b0, ENEMY_PLANE_HALF_HEIGHT});

  // BCD +1 with ripple carry; 9999 wraps to 0000. Any digit at or above 9
  // rolls to 0, so an out-of-range digit can never survive an increment.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state / next-output logic. Nothing moves except on a frame tick.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_exp_cnt_nxt  = r_exp_cnt;
    w_dead_cnt_nxt = r_dead_cnt;
    w_score_nxt    = r_score;
    w_hit_nxt      = 1'b0;
    w_respawn_nxt  = 1'b0;

    if (vs_neg) begin
      case (r_state)
        ST_ALIVE: begin
          if (bullet_valid && w_overlap) begin
            w_state_nxt   = ST_EXPLODE;
            w_exp_cnt_nxt = 6'd0;
            w_score_nxt   = bcd_inc(r_score);
            w_hit_nxt     = 1'b1;
          end
        end
        ST_EXPLODE: begin
          if (r_exp_cnt == EXPLODE_FRAMES - 6'd1) begin
            w_state_nxt    = ST_DEAD;
            w_exp_cnt_nxt  = 6'd0;
            w_dead_cnt_nxt = 7'd0;
          end else begin
            w_exp_cnt_nxt = r_exp_cnt + 6'd1;
          end
        end
        ST_DEAD: begin
          if (r_dead_cnt == RESPAWN_FRAMES - 7'd1) begin
            w_state_nxt    = ST_ALIVE;
            w_dead_cnt_nxt = 7'd0;
            w_respawn_nxt  = 1'b1;
          end else begin
            w_dead_cnt_nxt = r_dead_cnt + 7'd1;
          end
        end
        default: begin
          w_state_nxt    = ST_ALIVE;
          w_exp_cnt_nxt  = 6'd0;
          w_dead_cnt_nxt = 7'd0;
        end
      endcase
    end

    // Registered status outputs are computed from the next state so they
    // change on the same edge as the state itself.
    w_alive_nxt = (w_state_nxt == ST_ALIVE);
    w_frame_nxt = (w_state_nxt == ST_EXPLODE) ? w_exp_cnt_nxt[4:2] : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_ALIVE;
      r_exp_cnt  <= 6'd0;
      r_dead_cnt <= 7'd0;
      r_score    <= 16'h0000;
      r_hit      <= 1'b0;
      r_respawn  <= 1'b0;
      r_alive    <= 1'b1;
      r_frame    <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_exp_cnt  <= w_exp_cnt_nxt;
      r_dead_cnt <= w_dead_cnt_nxt;
      r_score    <= w_score_nxt;
      r_hit      <= w_hit_nxt;
      r_respawn  <= w_respawn_nxt;
      r_alive    <= w_alive_nxt;
      r_frame    <= w_frame_nxt;
    end
  end

  // hit and bullet_clear are the same event seen by two consumers.
  assign hit           = r_hit;
  assign bullet_clear  = r_hit;
  assign respawn       = r_respawn;
  assign enemy_alive   = r_alive;
  assign explode_frame = r_frame;
  assign score         = r_score;

endmodule
`default_nettype wire

// File: doc/enemy_hit_detect.md
ENEMY_HIT_DETECT -- requirements
Module: enemy_hit_detect

Interface
REQ-001 Parameter ENEMY_PLANE_HALF_WIDTH, default 11'd64, sets the enemy hit-box half width in pixels.
REQ-002 Parameter ENEMY_PLANE_HALF_HEIGHT, default 11'd64, sets the enemy hit-box half height in pixels.
REQ-003 Parameter EXPLODE_FRAMES, default 6'd32, sets the explosion duration in frames.
REQ-004 Parameter RESPAWN_FRAMES, default 7'd60, sets the dead-time in frames before respawn.
REQ-005 Port clk  input  1  system clock; the single clock domain.
REQ-006 Port rst  input  1  reset; asynchronous, active-high.
REQ-007 Port vs_neg  input  1  one-cycle pulse at the vertical-sync falling edge, i.e. the frame tick.
REQ-008 Port enemy_x  input  11  enemy centre x, from enemy_position.
REQ-009 Port enemy_y  input  11  enemy centre y, from enemy_position.
REQ-010 Port bullet_x  input  11  player bullet centre x.
REQ-011 Port bullet_y  input  11  player bullet centre y.
REQ-012 Port bullet_valid  input  1  the bullet is in flight.
REQ-013 Port hit  output  1  one-cycle pulse when a hit is registered.
REQ-014 Port bullet_clear  output  1  one-cycle pulse requesting that the bullet owner retire the bullet; coincident with hit.
REQ-015 Port enemy_alive  output  1  enemy is drawable and hittable.
REQ-016 Port explode_frame  output  3  explosion sprite index; valid while exploding, 0 otherwise.
REQ-017 Port respawn  output  1  one-cycle pulse on return to ALIVE.
REQ-018 Port score  output  16  four BCD digits; [15:12] is the thousands digit.

Function
REQ-019 The FSM SHALL have states ALIVE, EXPLODE and DEAD, and all state and counter updates SHALL occur only on clk edges where vs_neg=1.
REQ-020 Overlap SHALL be computed with 12-bit signed differences dx=bullet_x-enemy_x and dy=bullet_y-enemy_y, with no 11-bit wrap.
REQ-021 Overlap SHALL be true iff |dx| < ENEMY_PLANE_HALF_WIDTH and |dy| < ENEMY_PLANE_HALF_HEIGHT; equality counts as no hit.
REQ-022 In ALIVE, when vs_neg=1, bullet_valid=1 and overlap is true, the next edge SHALL set the state to EXPLODE, clear the frame counter, increment score, and pulse hit and bullet_clear for exactly one cycle (latency 1 clk from the vs_neg cycle).
REQ-023 Inputs SHALL be sampled only in the vs_neg cycle; overlap in any other cycle SHALL be ignored.
REQ-024 In EXPLODE and DEAD, hit evaluation SHALL be disabled; hit and bullet_clear SHALL stay 0 regardless of the bullet.
REQ-025 In EXPLODE, each vs_neg SHALL increment a 6-bit frame counter, and explode_frame SHALL equal frame counter [4:2].
REQ-026 In EXPLODE, on the vs_neg where the counter equals EXPLODE_FRAMES-1, the FSM SHALL go to DEAD and clear the counter.
REQ-027 In DEAD, each vs_neg SHALL increment a 7-bit counter; on the vs_neg where it equals RESPAWN_FRAMES-1, the FSM SHALL go to ALIVE and pulse respawn for one cycle.
REQ-028 enemy_alive SHALL be 1 only in ALIVE, driven from a register with no combinational path from the inputs.
REQ-029 score SHALL be a BCD counter: each digit rolls 9 to 0 with carry into the next digit, and 9999 +1 SHALL wrap to 0000.
REQ-030 No digit SHALL ever hold a value from 1010 to 1111.
REQ-031 Outputs hit, bullet_clear and respawn SHALL never be high for more than one consecutive cycle.

Reset
REQ-032 While rst=1, the block SHALL hold: state ALIVE, all counters 0, score 16'h0000, enemy_alive=1, explode_frame=0, and hit, bullet_clear and respawn=0.
REQ-033 Reset asserted mid-EXPLODE or mid-DEAD SHALL return the block to ALIVE immediately (asynchronously) and SHALL clear score.
REQ-034 After rst deassertion, the first vs_neg SHALL be evaluated normally.

Verification
REQ-035 Hit at centre: enemy (512,64), bullet (512,64), valid=1, vs_neg -> next cycle hit=1, bullet_clear=1, score=0001, enemy_alive=0.
REQ-036 Edge exclusion: enemy (512,64), bullet (576,64) (|dx|=64) -> no hit; bullet (575,64) -> hit.
REQ-037 Off-tick overlap: bullet overlapping with vs_neg=0 for 1000 cycles -> hit never asserted; score unchanged.
REQ-038 Lifecycle: after hit, apply 32 vs_neg -> explode_frame steps 0..7, then DEAD; apply 60 more vs_neg -> respawn pulse, enemy_alive=1.
REQ-039 Score carry: preload via 9999 hits -> score=16'h9999; one more hit -> 16'h0000; intermediate 0009 -> 0010 and 0099 -> 0100.
REQ-040 Reset mid-EXPLODE: after 10 vs_neg in EXPLODE, pulse rst -> enemy_alive=1 with no clk edge needed, score=0000, explode_frame=0.
